// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between IF fetch and MEM load/store; D wins conflicts
// unless MEM_ARB_RR_EN is defined (round-robin). Latency: grant +1, done +2 min.
// Backpressure: m_* held until m_ready or timeout; requests ignored outside IDLE.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic [DW-1:0]   if_rdata,
    output logic            if_done,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic [DW-1:0]   d_rdata,
    output logic            d_done,
    output logic            d_err,
    output logic            if_err,
    output logic            m_req,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_be,
    input  logic [DW-1:0]   m_rdata,
    input  logic            m_ready
);

    localparam int BW = DW / 8;
    localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_m_req;
    logic            r_m_we;
    logic [AW-1:0]   r_m_addr;
    logic [DW-1:0]   r_m_wdata;
    logic [BW-1:0]   r_m_be;
    logic [DW-1:0]   r_if_rdata;
    logic [DW-1:0]   r_d_rdata;
    logic            r_err;
    logic            r_srv_d;
    logic [CW-1:0]   r_cnt;

    logic            w_any_req;
    logic            w_gnt_d;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_timeout;
    logic [DW-1:0]   w_cap_rdata;

    assign w_any_req = if_req | d_req;

`ifdef MEM_ARB_RR_EN
    logic r_last_d;

    // On conflict the port that did not win last time goes next.
    assign w_gnt_d = d_req & (~if_req | ~r_last_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_d <= 1'b0;
        end else if (r_state == ST_IDLE && w_any_req) begin
            r_last_d <= w_gnt_d;
        end
    end
`else
    assign w_gnt_d = d_req;
`endif

    // The counter value after this cycle's increment; saturates instead of wrapping.
    assign w_cnt_nxt   = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + CW'(1);
    assign w_timeout   = (TIMEOUT != 0) && (w_cnt_nxt == TO_LIM);
    assign w_cap_rdata = r_m_we ? '0 : m_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any_req) w_state_nxt = ST_BUSY;
            ST_BUSY: if (m_ready || w_timeout) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        if_done = 1'b0;
        d_done  = 1'b0;
        if_err  = 1'b0;
        d_err   = 1'b0;
        if (r_state == ST_DONE) begin
            if_done = ~r_srv_d;
            d_done  = r_srv_d;
            if_err  = ~r_srv_d & r_err;
            d_err   = r_srv_d & r_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_req    <= 1'b0;
            r_m_we     <= 1'b0;
            r_m_addr   <= '0;
            r_m_wdata  <= '0;
            r_m_be     <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
            r_err      <= 1'b0;
            r_srv_d    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_m_req <= 1'b1;
                        r_srv_d <= w_gnt_d;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                        if (w_gnt_d) begin
                            r_m_addr  <= d_addr;
                            r_m_we    <= d_we;
                            r_m_wdata <= d_wdata;
                            r_m_be    <= d_be;
                        end else begin
                            r_m_addr  <= if_addr;
                            r_m_we    <= 1'b0;
                            r_m_wdata <= '0;
                            r_m_be    <= '0;
                        end
                    end
                end
                ST_BUSY: begin
                    r_cnt <= w_cnt_nxt;
                    if (m_ready) begin
                        r_m_req <= 1'b0;
                        r_err   <= 1'b0;
                        if (r_srv_d) r_d_rdata  <= w_cap_rdata;
                        else         r_if_rdata <= w_cap_rdata;
                    end else if (w_timeout) begin
                        r_m_req <= 1'b0;
                        r_err   <= 1'b1;
                        if (r_srv_d) r_d_rdata  <= '0;
                        else         r_if_rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_req    = r_m_req;
    assign m_we     = r_m_we;
    assign m_addr   = r_m_addr;
    assign m_wdata  = r_m_wdata;
    assign m_be     = r_m_be;
    assign if_rdata = r_if_rdata;
    assign d_rdata  = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [BW-1:0] d_be = '0;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          d_err;
    logic          if_err;
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [BW-1:0] m_be;
    logic [DW-1:0] m_rdata = '0;
    logic          m_ready = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err), .if_err(if_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_rdata(m_rdata), .m_ready(m_ready)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: last grant (for round-robin) and each port's last returned word.
    bit            mdl_last_d = 1'b0;
    logic [DW-1:0] mdl_if_rd  = '0;
    logic [DW-1:0] mdl_d_rd   = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit pick_d(input bit ifr, input bit dr);
        if (ifr && dr) begin
`ifdef MEM_ARB_RR_EN
            return !mdl_last_d;
`else
            return 1'b1;
`endif
        end
        return dr;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "/m_req"},    m_req,    0);
        check({tag, "/m_we"},     m_we,     0);
        check({tag, "/m_addr"},   m_addr,   0);
        check({tag, "/m_wdata"},  m_wdata,  0);
        check({tag, "/m_be"},     m_be,     0);
        check({tag, "/if_done"},  if_done,  0);
        check({tag, "/d_done"},   d_done,   0);
        check({tag, "/if_err"},   if_err,   0);
        check({tag, "/d_err"},    d_err,    0);
        check({tag, "/if_rdata"}, if_rdata, 0);
        check({tag, "/d_rdata"},  d_rdata,  0);
    endtask

    // Called one step after an edge with the DUT in IDLE and requests already applied.
    // lat = BUSY cycle in which m_ready is raised (0 = never).
    task automatic serve(input int lat, input logic [DW-1:0] rd, input bit drop,
                         input bit drop_early, input string tag);
        bit            exp_d;
        bit            we;
        bit            err;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [BW-1:0] be;
        logic [DW-1:0] exp_rd;
        int            k;
        exp_d      = pick_d(if_req, d_req);
        mdl_last_d = exp_d;
        a  = exp_d ? d_addr : if_addr;
        we = exp_d ? d_we : 1'b0;
        be = exp_d ? d_be : '0;
        wd = d_wdata;
        @(posedge clk); #1;
        check({tag, "/grant_we"}, m_we, we);
        check({tag, "/grant_be"}, m_be, be);
        if (exp_d) check({tag, "/grant_wdata"}, m_wdata, wd);
        k = 1;
        forever begin
            check({tag, "/busy_req"},  m_req,  1);
            check({tag, "/busy_addr"}, m_addr, a);
            check({tag, "/busy_done"}, {if_done, d_done}, 0);
            if (drop_early && k == 1) begin
                if (exp_d) d_req = 1'b0;
                else       if_req = 1'b0;
            end
            m_ready = (k == lat);
            m_rdata = (k == lat) ? rd : $urandom;
            if (k == lat || k == TO) break;
            @(posedge clk); #1;
            k++;
        end
        @(posedge clk); #1;
        m_ready = 1'b0;
        err    = (lat == 0) || (lat > TO);
        exp_rd = (err || we) ? '0 : rd;
        if (exp_d) mdl_d_rd = exp_rd;
        else       mdl_if_rd = exp_rd;
        check({tag, "/done_mreq"}, m_req, 0);
        if (exp_d) begin
            check({tag, "/d_done"},    d_done,  1);
            check({tag, "/if_done0"},  if_done, 0);
            check({tag, "/d_rdata"},   d_rdata, exp_rd);
            check({tag, "/d_err"},     d_err,   err);
            check({tag, "/if_err0"},   if_err,  0);
        end else begin
            check({tag, "/if_done"},   if_done,  1);
            check({tag, "/d_done0"},   d_done,   0);
            check({tag, "/if_rdata"},  if_rdata, exp_rd);
            check({tag, "/if_err"},    if_err,   err);
            check({tag, "/d_err0"},    d_err,    0);
        end
        if (drop) begin
            if (exp_d) d_req = 1'b0;
            else       if_req = 1'b0;
        end
        @(posedge clk); #1;
        check({tag, "/idle_done"},  {if_done, d_done, if_err, d_err}, 0);
        check({tag, "/idle_mreq"},  m_req,    0);
        check({tag, "/hold_if_rd"}, if_rdata, mdl_if_rd);
        check({tag, "/hold_d_rd"},  d_rdata,  mdl_d_rd);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #11;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_idle", m_req, 0);

        // Plain fetch, m_ready in the third BUSY cycle.
        if_req  = 1'b1;
        if_addr = 32'h0000_0040;
        serve(3, 32'h8C22_0004, 1'b1, 1'b0, "fetch");

        // Simultaneous requests.
        if_req  = 1'b1; if_addr = 32'h0000_0100;
        d_req   = 1'b1; d_we = 1'b0; d_addr = 32'h0000_2000; d_be = 4'hF; d_wdata = $urandom;
        serve(2, $urandom, 1'b1, 1'b0, "both_first");
        serve(1, $urandom, 1'b1, 1'b0, "both_second");

        // Store.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_1000; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
        serve(1, 32'h1234_5678, 1'b1, 1'b0, "store");

        // Load with memory never answering.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_3000;
        serve(0, $urandom, 1'b1, 1'b0, "timeout");

        // Both held high across four transactions.
        if_req = 1'b1; if_addr = 32'h0000_0200;
        d_req  = 1'b1; d_we = 1'b0; d_addr = 32'h0000_4000;
        for (int i = 0; i < 4; i++) serve(1 + ($urandom % 3), $urandom, 1'b0, 1'b0, "held");
        if_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;
        check("held_release", m_req, 0);

        // Random traffic; a request already pending is held with its fields unchanged.
        for (int i = 0; i < 40; i++) begin
            if (!if_req && $urandom_range(0, 1) == 1) begin
                if_req  = 1'b1;
                if_addr = {$urandom} & 32'hFFFF_FFFC;
            end
            if (!d_req && (!if_req || $urandom_range(0, 1) == 1)) begin
                d_req   = 1'b1;
                d_we    = $urandom_range(0, 1) == 1;
                d_addr  = $urandom;
                d_wdata = $urandom;
                d_be    = 4'($urandom);
            end
            serve($urandom_range(0, 6), $urandom, 1'b1, $urandom_range(0, 3) == 0, "rand");
        end
        if_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a fetch, then re-issue.
        if_req  = 1'b1;
        if_addr = 32'h0000_0080;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_abort_mreq", m_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        mdl_last_d = 1'b0;
        mdl_if_rd  = '0;
        mdl_d_rd   = '0;
        #2 rst_n = 1'b1;
        serve(2, 32'hCAFE_F00D, 1'b1, 1'b0, "reissue");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
